// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Purpose:
//   Takes the board-level reset and brings up NUM_DOMAINS downstream subsystems
//   one at a time in index order. After an initial hold period every domain
//   gets its own release delay, then the sequencer waits for that domain's
//   ready handshake before moving on. When the last domain reports ready the
//   block raises sys_ready. A domain that stays silent for READY_TIMEOUT cycles
//   parks the sequencer in a sticky fault state. Firmware can re-run the whole
//   sequence at any time through soft_rst_req.
//
// Ports:
//   clk           in   1            system clock, rising edge
//   rst           in   1            synchronous active-high reset
//   soft_rst_req  in   1            single-cycle request to restart the sequence
//   dom_ready     in   NUM_DOMAINS  per-domain init-done (only the current
//                                   waiting domain is looked at)
//   dom_rst       out  NUM_DOMAINS  per-domain reset, active-high, registered
//   sys_ready     out  1            every domain released and ready
//   fault         out  1            sticky ready-timeout flag
//   fault_stage   out  3            index of the domain that timed out
//   stage         out  3            index of the domain currently being sequenced
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int NUM_DOMAINS   = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int STAGE_DELAY   = 8,
    parameter int READY_TIMEOUT = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   soft_rst_req,
    input  logic [NUM_DOMAINS-1:0] dom_ready,
    output logic [NUM_DOMAINS-1:0] dom_rst,
    output logic                   sys_ready,
    output logic                   fault,
    output logic [2:0]             fault_stage,
    output logic [2:0]             stage
);

    // Terminal counts for the shared cycle counter, one per timed state.
    localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] DELAY_LAST   = 16'(STAGE_DELAY - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(READY_TIMEOUT - 1);
    localparam logic [2:0]  LAST_STAGE   = 3'(NUM_DOMAINS - 1);

    localparam logic [NUM_DOMAINS-1:0] ALL_HELD     = {NUM_DOMAINS{1'b1}};
    localparam logic [NUM_DOMAINS-1:0] ALL_RELEASED = {NUM_DOMAINS{1'b0}};

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_DELAY    = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_DONE     = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    // One-hot mask selecting the domain addressed by a stage index. Using a
    // mask instead of a variable bit-select keeps the index safely in range
    // when NUM_DOMAINS is smaller than the 3-bit stage encoding can express.
    function automatic logic [NUM_DOMAINS-1:0] stage_mask(input logic [2:0] idx);
        logic [NUM_DOMAINS-1:0] m;
        m = ALL_RELEASED;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (3'(i) == idx) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    // Registered state
    state_t                   state_r;
    logic [15:0]              cnt_r;
    logic [2:0]               stage_r;
    logic [NUM_DOMAINS-1:0]   dom_rst_r;
    logic                     sys_ready_r;
    logic                     fault_r;
    logic [2:0]               fault_stage_r;

    // Next-state values
    state_t                   state_s;
    logic [15:0]              cnt_s;
    logic [2:0]               stage_s;
    logic [NUM_DOMAINS-1:0]   dom_rst_s;
    logic                     sys_ready_s;
    logic                     fault_s;
    logic [2:0]               fault_stage_s;

    // Helpers for the domain currently being sequenced
    logic [NUM_DOMAINS-1:0]   cur_mask_s;
    logic                     cur_ready_s;

    assign cur_mask_s  = stage_mask(stage_r);
    // Only the current domain's ready bit is considered; held domains and
    // domains already brought up are masked off.
    assign cur_ready_s = |(dom_ready & cur_mask_s);

    // Next-state and next-output computation for the sequencing FSM.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        stage_s       = stage_r;
        dom_rst_s     = dom_rst_r;
        sys_ready_s   = sys_ready_r;
        fault_s       = fault_r;
        fault_stage_s = fault_stage_r;

        if (soft_rst_req) begin
            // A soft request looks exactly like a fresh reset: all domains are
            // re-held and the hold count starts over, even if already in HOLD.
            state_s       = ST_HOLD;
            cnt_s         = 16'd0;
            stage_s       = 3'd0;
            dom_rst_s     = ALL_HELD;
            sys_ready_s   = 1'b0;
            fault_s       = 1'b0;
            fault_stage_s = 3'd0;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    dom_rst_s   = ALL_HELD;
                    sys_ready_s = 1'b0;
                    if (cnt_r == HOLD_LAST) begin
                        cnt_s   = 16'd0;
                        state_s = ST_DELAY;
                    end else begin
                        cnt_s   = cnt_r + 16'd1;
                    end
                end

                ST_DELAY: begin
                    if (cnt_r == DELAY_LAST) begin
                        dom_rst_s = dom_rst_r & ~cur_mask_s;
                        cnt_s     = 16'd0;
                        state_s   = ST_WAIT_RDY;
                    end else begin
                        cnt_s     = cnt_r + 16'd1;
                    end
                end

                ST_WAIT_RDY: begin
                    // Ready is tested before the timeout so that a handshake
                    // arriving on the final allowed cycle still counts.
                    if (cur_ready_s) begin
                        cnt_s = 16'd0;
                        if (stage_r == LAST_STAGE) begin
                            state_s     = ST_DONE;
                            sys_ready_s = 1'b1;
                            dom_rst_s   = ALL_RELEASED;
                        end else begin
                            stage_s = stage_r + 3'd1;
                            state_s = ST_DELAY;
                        end
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        cnt_s         = 16'd0;
                        fault_s       = 1'b1;
                        fault_stage_s = stage_r;
                        state_s       = ST_FAULT;
                    end else begin
                        cnt_s = cnt_r + 16'd1;
                    end
                end

                ST_DONE: begin
                    // Terminal: later ready drops are deliberately ignored.
                    sys_ready_s = 1'b1;
                    dom_rst_s   = ALL_RELEASED;
                end

                ST_FAULT: begin
                    // Parked: released domains stay released, the rest stay
                    // held, until rst or soft_rst_req.
                    sys_ready_s = 1'b0;
                end

                default: begin
                    // Unreachable encoding: recover by re-running the sequence.
                    state_s       = ST_HOLD;
                    cnt_s         = 16'd0;
                    stage_s       = 3'd0;
                    dom_rst_s     = ALL_HELD;
                    sys_ready_s   = 1'b0;
                    fault_s       = 1'b0;
                    fault_stage_s = 3'd0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset to the held state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_HOLD;
            cnt_r         <= 16'd0;
            stage_r       <= 3'd0;
            dom_rst_r     <= ALL_HELD;
            sys_ready_r   <= 1'b0;
            fault_r       <= 1'b0;
            fault_stage_r <= 3'd0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            stage_r       <= stage_s;
            dom_rst_r     <= dom_rst_s;
            sys_ready_r   <= sys_ready_s;
            fault_r       <= fault_s;
            fault_stage_r <= fault_stage_s;
        end
    end

    assign dom_rst     = dom_rst_r;
    assign sys_ready   = sys_ready_r;
    assign fault       = fault_r;
    assign fault_stage = fault_stage_r;
    assign stage       = stage_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Self-checking bench for reset_sequencer with default parameters. Every
// scenario is described by a per-domain handshake latency (how many edges
// after its release a domain answers ready). From those latencies a timeline
// model computes, with plain arithmetic, when each domain is released, when
// its ready is accepted, and when fault or sys_ready appear. Each cycle the
// DUT outputs are compared with that timeline, indexed by the number of edges
// since the last restart (rst or soft_rst_req).
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int N = 4;
    localparam int H = 16;
    localparam int D = 8;
    localparam int T = 1000;

    logic         clk = 1'b0;
    logic         rst;
    logic         soft_rst_req;
    logic [N-1:0] dom_ready;
    logic [N-1:0] dom_rst;
    logic         sys_ready;
    logic         fault;
    logic [2:0]   fault_stage;
    logic [2:0]   stage;

    reset_sequencer #(
        .NUM_DOMAINS   (N),
        .HOLD_CYCLES   (H),
        .STAGE_DELAY   (D),
        .READY_TIMEOUT (T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .soft_rst_req (soft_rst_req),
        .dom_ready    (dom_ready),
        .dom_rst      (dom_rst),
        .sys_ready    (sys_ready),
        .fault        (fault),
        .fault_stage  (fault_stage),
        .stage        (stage)
    );

    // 100 MHz style free-running clock.
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Edges completed since the last restart edge.
    int c = 0;

    // Timeline model
    int lat [N];      // edges after release at which ready is presented
    int rel [N];      // edge count at which dom_rst[i] is released
    int det [N];      // edge count at which ready[i] is accepted
    int n_rel;        // number of domains that get released
    bit is_fault;
    int f_idx;
    int f_time;
    bit is_done;
    int done_time;

    // First observations since the last restart
    int fall_at [N];
    int sys_at;
    int fault_at;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s c=%0d got=%0h exp=%0h", tag, c, got, exp);
        end
    endtask

    // Build the timeline from the latency table.
    function automatic void plan();
        int t;
        is_fault  = 1'b0;
        is_done   = 1'b0;
        n_rel     = 0;
        f_idx     = 0;
        f_time    = 0;
        done_time = 0;
        t = H + D;
        for (int i = 0; i < N; i++) begin
            rel[i] = t;
            n_rel  = i + 1;
            if (lat[i] > T) begin
                is_fault = 1'b1;
                f_idx    = i;
                f_time   = t + T;
                break;
            end
            det[i] = t + lat[i];
            if (i == N - 1) begin
                is_done   = 1'b1;
                done_time = det[i];
            end else begin
                t = det[i] + D;
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_rst();
        logic [N-1:0] v;
        v = {N{1'b1}};
        for (int i = 0; i < n_rel; i++) begin
            if (c >= rel[i]) v[i] = 1'b0;
        end
        return v;
    endfunction

    function automatic int exp_stage();
        int s;
        s = 0;
        for (int i = 0; i < n_rel; i++) begin
            if (!(is_fault && i == f_idx) && c >= det[i]) s++;
        end
        if (s > N - 1) s = N - 1;
        return s;
    endfunction

    function automatic bit exp_sys();
        return is_done && (c >= done_time);
    endfunction

    function automatic bit exp_fault();
        return is_fault && (c >= f_time);
    endfunction

    // Ready pattern for edge number e: silent while the domain is being
    // waited on, high exactly on its answer edge, random noise everywhere the
    // sequencer must not be looking.
    function automatic logic [N-1:0] ready_for_edge(input int e);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) begin
            v[i] = 1'($urandom_range(0, 1));
            if (i < n_rel && e > rel[i]) begin
                if (is_fault && i == f_idx) begin
                    if (e <= f_time) v[i] = 1'b0;
                end else if (e < det[i]) begin
                    v[i] = 1'b0;
                end else if (e == det[i]) begin
                    v[i] = 1'b1;
                end
            end
        end
        return v;
    endfunction

    task automatic step(input bit r, input bit s);
        rst          = r;
        soft_rst_req = s;
        if (r || s) dom_ready = N'($urandom);
        else        dom_ready = ready_for_edge(c + 1);
        @(posedge clk);
        #1;
        if (r || s) begin
            c = 0;
            for (int i = 0; i < N; i++) fall_at[i] = -1;
            sys_at   = -1;
            fault_at = -1;
        end else begin
            c++;
        end
        for (int i = 0; i < N; i++) begin
            if (dom_rst[i] == 1'b0 && fall_at[i] < 0) fall_at[i] = c;
        end
        if (sys_ready == 1'b1 && sys_at < 0)   sys_at   = c;
        if (fault == 1'b1 && fault_at < 0)     fault_at = c;
        check_val("dom_rst",     32'(dom_rst),     32'(exp_rst()));
        check_val("stage",       32'(stage),       32'(exp_stage()));
        check_val("sys_ready",   32'(sys_ready),   32'(exp_sys()));
        check_val("fault",       32'(fault),       32'(exp_fault()));
        check_val("fault_stage", 32'(fault_stage), exp_fault() ? 32'(f_idx) : 32'd0);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0);
    endtask

    task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
        lat[0] = l0;
        lat[1] = l1;
        lat[2] = l2;
        lat[3] = l3;
        plan();
    endtask

    // Release times for an always-ready system with default parameters.
    task automatic check_nominal();
        check_val("rel0", 32'(fall_at[0]), 32'd24);
        check_val("rel1", 32'(fall_at[1]), 32'd33);
        check_val("rel2", 32'(fall_at[2]), 32'd42);
        check_val("rel3", 32'(fall_at[3]), 32'd51);
        check_val("sys_at", 32'(sys_at),   32'd52);
    endtask

    initial begin
        int full;
        int len;
        int kind;
        int pick;

        rst          = 1'b1;
        soft_rst_req = 1'b0;
        dom_ready    = {N{1'b0}};

        // Power-on: rst for 5 cycles, every domain answers immediately.
        set_lat(1, 1, 1, 1);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
        run(60);
        check_nominal();

        // Soft restart from DONE repeats the exact same timeline.
        step(1'b0, 1'b1);
        check_val("soft_dom_rst", 32'(dom_rst), 32'h0000000F);
        run(60);
        check_nominal();

        // Domain 2 never answers: timeout fault 1000 cycles after its release.
        set_lat(1, 1, T + 1, 1);
        step(1'b0, 1'b1);
        run(1050);
        check_val("fault_gap", 32'(fault_at - fall_at[2]), 32'd1000);
        check_val("fault_rst", 32'(dom_rst), 32'h00000008);

        // Soft restart out of FAULT, then rst in the middle of stage-1 DELAY.
        set_lat(1, 1, 1, 1);
        step(1'b0, 1'b1);
        check_val("unfault", 32'(fault), 32'd0);
        run(28);
        step(1'b1, 1'b0);
        check_val("mid_rst_stage", 32'(stage), 32'd0);
        run(60);
        check_nominal();

        // Ready on the very edge the timeout would fire: no fault.
        set_lat(1, T, 1, 1);
        step(1'b0, 1'b1);
        run(1060);
        check_val("no_fault", 32'(fault_at), 32'hFFFFFFFF);
        check_val("late_rel2", 32'(fall_at[2]), 32'd1041);
        check_val("late_sys", 32'(sys_at), 32'd1051);

        // Randomised latencies, restart styles and early restarts.
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < N; i++) begin
                pick = $urandom_range(0, 9);
                if (pick == 0)      lat[i] = T;
                else if (pick == 1) lat[i] = T + 1;
                else if (pick == 2) lat[i] = T - 1;
                else                lat[i] = $urandom_range(1, 30);
            end
            plan();
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                step(1'b0, 1'b1);
            end else if (kind == 1) begin
                len = $urandom_range(1, 3);
                for (int k = 0; k < len; k++) step(1'b1, 1'b0);
            end else begin
                step(1'b1, 1'b1);
            end
            full = is_done ? done_time + 5 : f_time + 5;
            if ($urandom_range(0, 3) == 0) len = $urandom_range(1, full);
            else                           len = full;
            run(len);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
